rv_run_controller: RTL



---
 rtl/rv_run_pkg.sv | 27 ++
 rtl/rv_sat_counter.sv | 26 ++
 rtl/rv_run_controller.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/rv_run_pkg.sv
// rv_run_pkg: shared types and constants for the RISC-V run controller.
//   run_state_e     - controller FSM states
//   TOHOST_ADDR_DEF - default byte address of the completion mailbox
//   run_status_t    - latched end-of-run status flags
// Optional feature macro: RV_RUN_LOOP_DETECT_EN (adds the loop_halt flag).
package rv_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RST_HOLD,
    ST_RUN,
    ST_DONE
  } run_state_e;

  localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_0FFC;

  // The result payload is DATA_W-1 bits wide, so it is registered alongside
  // this struct rather than inside it.
  typedef struct packed {
    logic pass;
    logic timed_out;
`ifdef RV_RUN_LOOP_DETECT_EN
    logic loop_halt;
`endif
  } run_status_t;

endpackage

// File: rtl/rv_sat_counter.sv
// rv_sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   clr_i         - synchronous clear (wins over en_i)
//   en_i          - count enable
//   cnt_o         - current (registered) count
module rv_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  cnt_q <= '0;
    else if (clr_i)               cnt_q <= '0;
    else if (en_i && cnt_q != '1) cnt_q <= cnt_q + W'(1);
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/rv_run_controller.sv
// rv_run_controller: sequences reset for a RISC-V core under test, counts
// run cycles, watches for the tohost completion store and enforces a timeout.
//   CLK, RST       - clock, asynchronous active-low reset
//   start          - one-cycle pulse, launches a run from IDLE or DONE
//   mem_we/addr/wdata - core data-memory write port (observed in RUN only)
//   core_rst_n     - active-low reset to the core (low except in RUN)
//   running, done  - state indicators
//   pass, timed_out, result - end-of-run status, valid while done
//   cycle_count    - RUN cycles elapsed (saturating), frozen in DONE
// Optional feature macro: RV_RUN_LOOP_DETECT_EN adds parameter LOOP_CYCLES,
// input pc and output loop_halt; a pc stuck for LOOP_CYCLES run cycles ends
// the run. Completion priority: tohost > loop > timeout.
module rv_run_controller
  import rv_run_pkg::*;
#(
  parameter int                RST_CYCLES     = 4,
  parameter int                TIMEOUT_CYCLES = 1000,
  parameter int                CNT_W          = 32,
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(TOHOST_ADDR_DEF)
`ifdef RV_RUN_LOOP_DETECT_EN
  , parameter int              LOOP_CYCLES    = 8
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
`ifdef RV_RUN_LOOP_DETECT_EN
  input  logic [ADDR_W-1:0] pc,
  output logic              loop_halt,
`endif
  output logic              core_rst_n,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timed_out,
  output logic [DATA_W-2:0] result,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int HOLD_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);
  localparam logic [CNT_W:0] TMO_LIM = (CNT_W+1)'(TIMEOUT_CYCLES);

  run_state_e        state_q;
  run_status_t       stat_q;
  logic [DATA_W-2:0] result_q;
  logic              core_rst_n_q, running_q, done_q;

  logic              launch, in_run, in_hold, hold_last;
  logic              tohost_hit, timeout_hit;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CNT_W-1:0]  cyc_cnt;

  assign launch  = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign in_run  = (state_q == ST_RUN);
  assign in_hold = (state_q == ST_RST_HOLD);

  rv_sat_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk_i(CLK), .rst_ni(RST), .clr_i(launch), .en_i(in_hold), .cnt_o(hold_cnt)
  );

  // Enabled on the completing RUN cycle too, so the frozen count includes it.
  rv_sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .clk_i(CLK), .rst_ni(RST), .clr_i(launch), .en_i(in_run), .cnt_o(cyc_cnt)
  );

  assign hold_last  = (hold_cnt == HOLD_W'(RST_CYCLES - 1));
  assign tohost_hit = in_run && mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
  // Look at the count this cycle will produce so DONE shows exactly the limit.
  assign timeout_hit = in_run && (({1'b0, cyc_cnt} + (CNT_W+1)'(1)) >= TMO_LIM);

`ifdef RV_RUN_LOOP_DETECT_EN
  localparam int LOOP_W = $clog2(LOOP_CYCLES + 1);

  logic [ADDR_W-1:0] pc_prev_q;
  logic              pc_vld_q, pc_same, loop_hit;
  logic [LOOP_W-1:0] loop_cnt;

  // pc_vld_q is low on the first RUN cycle, so a stale pc from a previous
  // run cannot extend the streak.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_prev_q <= '0;
      pc_vld_q  <= 1'b0;
    end else begin
      pc_prev_q <= pc;
      pc_vld_q  <= in_run;
    end
  end

  assign pc_same = pc_vld_q && (pc == pc_prev_q);

  // loop_cnt holds (streak length - 2) while the pc keeps repeating.
  rv_sat_counter #(.W(LOOP_W)) u_loop_cnt (
    .clk_i(CLK), .rst_ni(RST), .clr_i(!(in_run && pc_same)), .en_i(1'b1), .cnt_o(loop_cnt)
  );

  assign loop_hit = in_run &&
    ((pc_same ? 32'(loop_cnt) + 32'd2 : 32'd1) >= 32'(LOOP_CYCLES));
  assign loop_halt = stat_q.loop_halt;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      stat_q       <= '0;
      result_q     <= '0;
      core_rst_n_q <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q  <= ST_RST_HOLD;
            stat_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
          end
        end
        ST_RST_HOLD: begin
          if (hold_last) begin
            state_q      <= ST_RUN;
            core_rst_n_q <= 1'b1;
            running_q    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (tohost_hit) begin
            state_q      <= ST_DONE;
            core_rst_n_q <= 1'b0;
            running_q    <= 1'b0;
            done_q       <= 1'b1;
            stat_q.pass  <= (mem_wdata == DATA_W'(1));
            result_q     <= mem_wdata[DATA_W-1:1];
          end
`ifdef RV_RUN_LOOP_DETECT_EN
          else if (loop_hit) begin
            state_q          <= ST_DONE;
            core_rst_n_q     <= 1'b0;
            running_q        <= 1'b0;
            done_q           <= 1'b1;
            stat_q.loop_halt <= 1'b1;
          end
`endif
          else if (timeout_hit) begin
            state_q          <= ST_DONE;
            core_rst_n_q     <= 1'b0;
            running_q        <= 1'b0;
            done_q           <= 1'b1;
            stat_q.timed_out <= 1'b1;
          end
        end
      endcase
    end
  end

  assign core_rst_n  = core_rst_n_q;
  assign running     = running_q;
  assign done        = done_q;
  assign pass        = stat_q.pass;
  assign timed_out   = stat_q.timed_out;
  assign result      = result_q;
  assign cycle_count = cyc_cnt;

endmodule
